// File: rtl/fp_buf_pkg.sv
// fp_buf_pkg -- shared definitions for the fp_pipe_buf elastic buffer.
//   MANT_W_DEF / EXP_W_DEF : default mantissa / exponent widths
//   DEPTH_MAX              : largest supported number of stages
//   fp_word_t              : packed {sign, exponent, mantissa} at default widths
//   occ_width()            : bit width needed to count 0..depth full stages
package fp_buf_pkg;

   localparam int MANT_W_DEF = 24;
   localparam int EXP_W_DEF  = 8;
   localparam int DEPTH_MAX  = 8;

   typedef struct packed {
      logic                 sign;
      logic [EXP_W_DEF-1:0]  expo;
      logic [MANT_W_DEF-1:0] mant;
   } fp_word_t;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fp_buf_stage.sv
// fp_buf_stage -- one valid+data register of the elastic buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of the valid bit
//   adv        : this stage may load from upstream at the next edge
//   up_valid   : upstream stage (or buffer input) holds a word
//   up_data    : upstream word {sign, exponent, mantissa}
//   valid      : this stage holds a word
//   data       : word held by this stage
module fp_buf_stage #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         adv,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (adv) begin
         valid <= up_valid;
      end
   end

   // Data only moves when a real word arrives; an emptied stage keeps its
   // old contents, which downstream ignores because valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (adv && up_valid) begin
         data <= up_data;
      end
   end

endmodule

// File: rtl/fp_pipe_buf.sv
// fp_pipe_buf -- elastic valid/ready pipeline buffer for {sign, exp, mant}
// floating-point words, DEPTH register stages with bubble collapsing.
//   CLK, RST_N           : clock, asynchronous active-low reset
//   FLUSH                : synchronous clear of every stage
//   IN_VALID / IN_READY  : upstream handshake, ZS/ZEN/ZN input word
//   OUT_VALID / OUT_READY: downstream handshake, ZS1/ZEN1/ZN1 output word
//   OCCUPANCY            : number of full stages
//   STALL_CNT            : saturating count of stalled output cycles,
//                          present only when FP_PIPE_BUF_STALL_CNT_EN is defined
module fp_pipe_buf
   import fp_buf_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         FLUSH,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   input  logic [MANT_W-1:0]            ZN,
   input  logic [EXP_W-1:0]             ZEN,
   input  logic                         ZS,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   output logic [MANT_W-1:0]            ZN1,
   output logic [EXP_W-1:0]             ZEN1,
   output logic                         ZS1,
   output logic [occ_width(DEPTH)-1:0]  OCCUPANCY
`ifdef FP_PIPE_BUF_STALL_CNT_EN
   ,
   output logic [15:0]                  STALL_CNT
`endif
);

   localparam int W     = 1 + EXP_W + MANT_W;
   localparam int OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] adv;
   logic [W-1:0]     data [DEPTH];
   logic             in_fire;
   logic             out_fire;

   // A stage may advance if it is empty or everything below it can move;
   // evaluated tail-first so an empty slot anywhere lets the words above it
   // collapse into it.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = !vld[DEPTH-1] | OUT_READY;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         adv[k] = !vld[k] | adv[k+1];
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic         up_vld;
      logic [W-1:0] up_dat;
      if (k == 0) begin : g_head
         assign up_vld = IN_VALID;
         assign up_dat = {ZS, ZEN, ZN};
      end else begin : g_body
         assign up_vld = vld[k-1];
         assign up_dat = data[k-1];
      end
      fp_buf_stage #(.W(W)) u_stage (
         .clk      (CLK),
         .rst_n    (RST_N),
         .flush    (FLUSH),
         .adv      (adv[k]),
         .up_valid (up_vld),
         .up_data  (up_dat),
         .valid    (vld[k]),
         .data     (data[k])
      );
   end

   // RST_N gates ready so upstream sees no acceptance while reset is held.
   assign IN_READY          = adv[0] & !FLUSH & RST_N;
   assign OUT_VALID         = vld[DEPTH-1];
   assign {ZS1, ZEN1, ZN1}  = data[DEPTH-1];

   assign in_fire  = IN_VALID & IN_READY;
   assign out_fire = OUT_VALID & OUT_READY;

   // Running count tracks popcount(vld): words enter only through stage 0
   // and leave only through the last stage.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OCCUPANCY <= '0;
      end else if (FLUSH) begin
         OCCUPANCY <= '0;
      end else if (in_fire && !out_fire) begin
         OCCUPANCY <= OCCUPANCY + OCC_W'(1);
      end else if (!in_fire && out_fire) begin
         OCCUPANCY <= OCCUPANCY - OCC_W'(1);
      end
   end

`ifdef FP_PIPE_BUF_STALL_CNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STALL_CNT <= '0;
      end else if (FLUSH) begin
         STALL_CNT <= '0;
      end else if (OUT_VALID && !OUT_READY && (STALL_CNT != 16'hFFFF)) begin
         STALL_CNT <= STALL_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_pipe_buf.sv
// tb_fp_pipe_buf -- randomized scoreboard bench for fp_pipe_buf (DEPTH=4).
// The reference keeps accepted words in an ordered queue, each tagged with
// the slot it occupies; words slide toward the output whenever the slot ahead
// is free, which is the bubble-collapsing behaviour in plain terms.
module tb_fp_pipe_buf;

   localparam int MW = 24;
   localparam int EW = 8;
   localparam int D  = 4;
   localparam int W  = 1 + EW + MW;
   localparam int OW = $clog2(D + 1);

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          FLUSH;
   logic          IN_VALID;
   logic          IN_READY;
   logic [MW-1:0] ZN;
   logic [EW-1:0] ZEN;
   logic          ZS;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [MW-1:0] ZN1;
   logic [EW-1:0] ZEN1;
   logic          ZS1;
   logic [OW-1:0] OCCUPANCY;
`ifdef FP_PIPE_BUF_STALL_CNT_EN
   logic [15:0]   STALL_CNT;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] w;
      int           pos;
   } ent_t;

   ent_t        mq[$];
   int unsigned stall_m = 0;
   logic        exp_ov;
   logic        exp_rdy;
   int          limit;

   always #5 CLK = ~CLK;

   fp_pipe_buf #(.MANT_W(MW), .EXP_W(EW), .DEPTH(D)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .ZN        (ZN),
      .ZEN       (ZEN),
      .ZS        (ZS),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .ZN1       (ZN1),
      .ZEN1      (ZEN1),
      .ZS1       (ZS1),
      .OCCUPANCY (OCCUPANCY)
`ifdef FP_PIPE_BUF_STALL_CNT_EN
      ,
      .STALL_CNT (STALL_CNT)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor / scoreboard: compare the DUT against the reference, then
   // advance the reference by the edge that follows.
   always @(negedge CLK) begin
      if (!RST_N) begin
         chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
         chk("rst_occupancy", 64'(OCCUPANCY), 64'd0);
         chk("rst_in_ready",  64'(IN_READY),  64'd0);
         chk("rst_out_data",  64'({ZS1, ZEN1, ZN1}), 64'd0);
         mq.delete();
         stall_m = 0;
      end else begin
         exp_ov  = (mq.size() > 0) && (mq[0].pos == D - 1);
         exp_rdy = ((mq.size() < D) || OUT_READY) && !FLUSH;
         chk("out_valid", 64'(OUT_VALID), 64'(exp_ov));
         chk("occupancy", 64'(OCCUPANCY), 64'(mq.size()));
         chk("in_ready",  64'(IN_READY),  64'(exp_rdy));
         if (OUT_VALID && exp_ov)
            chk("out_data", 64'({ZS1, ZEN1, ZN1}), 64'(mq[0].w));
`ifdef FP_PIPE_BUF_STALL_CNT_EN
         chk("stall_cnt", 64'(STALL_CNT), 64'(stall_m));
`endif
         if (FLUSH) begin
            mq.delete();
            stall_m = 0;
         end else begin
            if (exp_ov && !OUT_READY && stall_m < 65535)
               stall_m++;
            if (exp_ov && OUT_READY)
               void'(mq.pop_front());
            limit = D;
            foreach (mq[i]) begin
               if (mq[i].pos + 1 < limit)
                  mq[i].pos++;
               limit = mq[i].pos;
            end
            if (IN_VALID && exp_rdy)
               mq.push_back('{w: {ZS, ZEN, ZN}, pos: 0});
         end
      end
   end

   task automatic step(input logic iv, input logic [W-1:0] w, input logic ordy, input logic fl);
      IN_VALID         = iv;
      {ZS, ZEN, ZN}    = w;
      OUT_READY        = ordy;
      FLUSH            = fl;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_word();
      return W'({$urandom(), $urandom()});
   endfunction

   function automatic logic pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   initial begin
      RST_N     = 1'b0;
      FLUSH     = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      {ZS, ZEN, ZN} = '0;
      repeat (3) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      step(0, '0, 1, 0);

      // Streaming at full rate with the reference word pattern, then random.
      step(1, {1'b0, 8'h7F, 24'h400000}, 1, 0);
      step(1, {1'b1, 8'h80, 24'hC00000}, 1, 0);
      step(1, {1'b0, 8'h01, 24'h000001}, 1, 0);
      step(1, {1'b1, 8'hFF, 24'hFFFFFF}, 1, 0);
      repeat (12) step(1, rnd_word(), 1, 0);
      repeat (6) step(0, '0, 1, 0);

      // Backpressure fill: 6 offered, 4 accepted, then drain.
      repeat (6) step(1, rnd_word(), 0, 0);
      repeat (8) step(0, '0, 1, 0);

      // Bubble collapse: one word reaches the output, then 3 more under stall.
      step(1, rnd_word(), 0, 0);
      repeat (4) step(0, '0, 0, 0);
      repeat (3) step(1, rnd_word(), 0, 0);
      repeat (2) step(0, '0, 0, 0);
      repeat (6) step(0, '0, 1, 0);

      // Flush with three words held and a word offered at the same edge.
      repeat (3) step(1, rnd_word(), 0, 0);
      step(1, rnd_word(), 1, 1);
      repeat (2) step(0, '0, 0, 0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 1500; i++)
         step(pct(70), rnd_word(), pct(60), pct(3));
      repeat (6) step(0, '0, 1, 0);

      // Reset mid-stream: two words held, reset asserted between edges.
      repeat (2) step(1, rnd_word(), 0, 0);
      repeat (3) step(0, '0, 0, 0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(OUT_VALID), 64'd0);
      chk("async_rst_occupancy", 64'(OCCUPANCY), 64'd0);
      chk("async_rst_out_data",  64'({ZS1, ZEN1, ZN1}), 64'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      step(0, '0, 1, 0);

`ifdef FP_PIPE_BUF_STALL_CNT_EN
      // Long stall drives the counter into saturation, then flush clears it.
      step(1, rnd_word(), 0, 0);
      repeat (70000) step(0, '0, 0, 0);
      chk("stall_saturated", 64'(STALL_CNT), 64'hFFFF);
      step(0, '0, 0, 1);
      repeat (2) step(0, '0, 1, 0);
`endif

      repeat (2) step(0, '0, 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
